vce_huc6260: RTL and testbench

//  Video colour encoder directly downstream of the HuC6270 VDC. Takes the VDC's 9-bit

---
 rtl/vce_huc6260_pkg.sv | 40 ++++
 rtl/vce_huc6260_palette_ram.sv | 29 ++
 rtl/vce_huc6260.sv | 178 +++++++++++++++++
 tb/tb_vce_huc6260.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vce_huc6260_pkg.sv
// vce_huc6260_pkg -- shared types and constants for the HuC6260 colour encoder.
//   rgb9_t      : one colour table entry, packed {g, r, b}, 3 bits each
//   vce_reg_t   : CPU register map selected by address A[2:0]
//   luma()      : grey level used by the optional black/white mode
//                 (VCE_BW_MODE_EN)
package vce_huc6260_pkg;

  localparam int PAL_ENTRIES = 512;
  localparam int PAL_AW      = $clog2(PAL_ENTRIES);
  localparam int CH_W        = 3;
  localparam int PAL_DW      = 3 * CH_W;
  localparam int SYNC_DLY    = 2;

  localparam logic [PAL_AW-1:0] OVERSCAN_IDX = 9'h100;
  localparam logic [PAL_AW-1:0] BACKDROP_IDX = 9'h000;

  typedef struct packed {
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] b;
  } rgb9_t;

  typedef enum logic [2:0] {
    CR     = 3'd0,
    CTA_LO = 3'd2,
    CTA_HI = 3'd3,
    CTW_LO = 3'd4,
    CTW_HI = 3'd5,
    CTR_LO = 3'd6,
    CTR_HI = 3'd7
  } vce_reg_t;

  // Y = (R + 2G + B) / 4; the 5-bit sum cannot overflow (max 28).
  function automatic logic [CH_W-1:0] luma(input rgb9_t c);
    logic [CH_W+1:0] sum;
    sum = {2'b00, c.r} + {1'b0, c.g, 1'b0} + {2'b00, c.b};
    return sum[CH_W+1:2];
  endfunction

endpackage

// File: rtl/vce_huc6260_palette_ram.sv
// vce_huc6260_palette_ram -- 512x9 simple dual-port colour table.
//   Port A (CPU): synchronous read of a_addr every cycle, write when a_we.
//   Port B (pixel): synchronous read of b_addr every cycle.
//   Both reads return the value held before a same-cycle write
//   (read-before-write). Contents are not reset.
module vce_huc6260_palette_ram
  import vce_huc6260_pkg::*;
(
  input  logic              clock,
  input  logic              a_we,
  input  logic [PAL_AW-1:0] a_addr,
  input  logic [PAL_DW-1:0] a_wdata,
  output logic [PAL_DW-1:0] a_rdata,
  input  logic [PAL_AW-1:0] b_addr,
  output logic [PAL_DW-1:0] b_rdata
);

  logic [PAL_DW-1:0] mem [PAL_ENTRIES];

  // Table storage: CPU write plus two registered reads of the old contents.
  always_ff @(posedge clock) begin
    if (a_we) begin
      mem[a_addr] <= a_wdata;
    end
    a_rdata <= mem[a_addr];
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/vce_huc6260.sv
// vce_huc6260 -- HuC6260 video colour encoder.
//   CPU side : CS_n/WR_n/RD_n strobes, A[2:0] register select, DI in, DO out.
//   Pixel in : VD[8:0] from the VDC, in_disp, HSYNC_n_in, VSYNC_n_in.
//   Pixel out: R/G/B (3 bits each), HSYNC_n, VSYNC_n, disp_out, all two
//              cycles after the corresponding input.
//   Optional : define VCE_BW_MODE_EN to make CR[7] select greyscale output.
module vce_huc6260
  import vce_huc6260_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            CS_n,
  input  logic            WR_n,
  input  logic            RD_n,
  input  logic [2:0]      A,
  input  logic [7:0]      DI,
  output logic [7:0]      DO,
  input  logic [8:0]      VD,
  input  logic            in_disp,
  input  logic            HSYNC_n_in,
  input  logic            VSYNC_n_in,
  output logic [CH_W-1:0] R,
  output logic [CH_W-1:0] G,
  output logic [CH_W-1:0] B,
  output logic            HSYNC_n,
  output logic            VSYNC_n,
  output logic            disp_out
);

  logic [7:0]        cr_r;
  logic [PAL_AW-1:0] cta_r;
  logic [7:0]        wdata_lo_r;
  logic              wr_prev_r;
  logic              rd7_prev_r;

  logic              wr_act_s;
  logic              wr_pulse_s;
  logic              rd_act_s;
  logic              rd7_act_s;
  logic              rd7_done_s;
  logic              pal_we_s;
  vce_reg_t          reg_sel_s;

  logic [PAL_DW-1:0] rdata_s;
  logic [PAL_DW-1:0] pix_data_s;
  logic [PAL_AW-1:0] pix_addr_s;
  rgb9_t             pix_s;
  rgb9_t             out_rgb_s;

  logic              disp_d1_r;
  logic              hs_d1_r;
  logic              vs_d1_r;

  logic              unused_cr_s;

  // Write acts only on the first cycle of an asserted strobe; a read with
  // both strobes low is suppressed so the write wins.
  assign wr_act_s   = ~CS_n & ~WR_n;
  assign wr_pulse_s = wr_act_s & ~wr_prev_r;
  assign rd_act_s   = ~CS_n & ~RD_n & ~wr_act_s;
  assign rd7_act_s  = rd_act_s & (A == 3'd7);
  assign rd7_done_s = rd7_prev_r & ~rd7_act_s;
  assign reg_sel_s  = vce_reg_t'(A);
  assign pal_we_s   = wr_pulse_s & (reg_sel_s == CTW_HI);

  // Low dot-clock bits are held for software only; they drive no logic here.
  assign unused_cr_s = ^cr_r;

  // CPU register file, strobe history and colour table address counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cr_r       <= 8'h00;
      cta_r      <= 9'h000;
      wdata_lo_r <= 8'h00;
      wr_prev_r  <= 1'b0;
      rd7_prev_r <= 1'b0;
    end else begin
      wr_prev_r  <= wr_act_s;
      rd7_prev_r <= rd7_act_s;
      if (wr_pulse_s) begin
        case (reg_sel_s)
          CR:      cr_r        <= DI;
          CTA_LO:  cta_r[7:0]  <= DI;
          CTA_HI:  cta_r[8]    <= DI[0];
          CTW_LO:  wdata_lo_r  <= DI;
          CTW_HI:  cta_r       <= cta_r + 9'd1;
          default: ;
        endcase
      end else if (rd7_done_s) begin
        // High-byte read completes when the strobe is released.
        cta_r <= cta_r + 9'd1;
      end
    end
  end

  // CPU read data mux; the bus idles high.
  always_comb begin
    DO = 8'hFF;
    if (rd_act_s) begin
      case (A)
        3'd6:    DO = rdata_s[7:0];
        3'd7:    DO = {7'h7F, rdata_s[8]};
        default: DO = 8'hFF;
      endcase
    end else begin
      DO = 8'hFF;
    end
  end

  // Pixel address: overscan entry outside display, shared backdrop for
  // colour index 0 of any palette (BG or sprite), otherwise VD directly.
  always_comb begin
    pix_addr_s = VD;
    if (!in_disp) begin
      pix_addr_s = OVERSCAN_IDX;
    end else if (VD[3:0] == 4'h0) begin
      pix_addr_s = BACKDROP_IDX;
    end else begin
      pix_addr_s = VD;
    end
  end

  vce_huc6260_palette_ram u_ram (
    .clock   (clock),
    .a_we    (pal_we_s),
    .a_addr  (cta_r),
    .a_wdata ({DI[0], wdata_lo_r}),
    .a_rdata (rdata_s),
    .b_addr  (pix_addr_s),
    .b_rdata (pix_data_s)
  );

  // Colour / greyscale selection for the final stage.
  always_comb begin
    pix_s     = rgb9_t'(pix_data_s);
    out_rgb_s = pix_s;
`ifdef VCE_BW_MODE_EN
    if (cr_r[7]) begin
      out_rgb_s = '{g: luma(pix_s), r: luma(pix_s), b: luma(pix_s)};
    end else begin
      out_rgb_s = pix_s;
    end
`endif
  end

  // Strobe delay line stage 1, aligned with the RAM read stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_d1_r <= 1'b0;
      hs_d1_r   <= 1'b1;
      vs_d1_r   <= 1'b1;
    end else begin
      disp_d1_r <= in_disp;
      hs_d1_r   <= HSYNC_n_in;
      vs_d1_r   <= VSYNC_n_in;
    end
  end

  // Output stage: colour and strobes leave together, SYNC_DLY after input.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      R        <= 3'd0;
      G        <= 3'd0;
      B        <= 3'd0;
      HSYNC_n  <= 1'b1;
      VSYNC_n  <= 1'b1;
      disp_out <= 1'b0;
    end else begin
      R        <= out_rgb_s.r;
      G        <= out_rgb_s.g;
      B        <= out_rgb_s.b;
      HSYNC_n  <= hs_d1_r;
      VSYNC_n  <= vs_d1_r;
      disp_out <= disp_d1_r;
    end
  end

endmodule

// File: tb/tb_vce_huc6260.sv
// tb_vce_huc6260 -- scoreboard bench for vce_huc6260. Stimulus pushes the
// expected response (due cycle + value) into a queue; a monitor on the
// falling edge pops every entry due in that cycle and compares it.
// Build with VCE_BW_MODE_EN defined to exercise the greyscale expectations.
module tb_vce_huc6260;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       CS_n = 1'b1, WR_n = 1'b1, RD_n = 1'b1;
  logic [2:0] A = 3'd0;
  logic [7:0] DI = 8'h00;
  logic [7:0] DO;
  logic [8:0] VD = 9'h000;
  logic       in_disp = 1'b0, HSYNC_n_in = 1'b1, VSYNC_n_in = 1'b1;
  logic [2:0] R, G, B;
  logic       HSYNC_n, VSYNC_n, disp_out;

  vce_huc6260 dut (
    .clock(clock), .reset(reset), .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n),
    .A(A), .DI(DI), .DO(DO), .VD(VD), .in_disp(in_disp),
    .HSYNC_n_in(HSYNC_n_in), .VSYNC_n_in(VSYNC_n_in),
    .R(R), .G(G), .B(B), .HSYNC_n(HSYNC_n), .VSYNC_n(VSYNC_n),
    .disp_out(disp_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // kind 0: {G,R,B,HSYNC_n,VSYNC_n,disp_out}; kind 1: {4'h0, DO}
  typedef struct {
    int          due;
    int          kind;
    logic [11:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void push(input int due, input int kind,
                               input logic [11:0] e, input string nm);
    exp_t x;
    x.due = due; x.kind = kind; x.exp = e; x.name = nm;
    sb.push_back(x);
  endfunction

  // Monitor: compare every expectation due in this cycle.
  always @(negedge clock) begin
    automatic int i = 0;
    automatic logic [11:0] act;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        if (sb[i].kind == 0) act = {G, R, B, HSYNC_n, VSYNC_n, disp_out};
        else                 act = {4'h0, DO};
        n_checks++;
        if (act !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)",
                   sb[i].name, act, sb[i].exp, cyc);
        end
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d never checked, now %0d",
                 sb[i].name, sb[i].due, cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic w(input logic [2:0] a, input logic [7:0] d);
    CS_n = 1'b0; WR_n = 1'b0; A = a; DI = d;
    tick();
    CS_n = 1'b1; WR_n = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e, input string nm);
    CS_n = 1'b0; RD_n = 1'b0; A = a;
    push(cyc, 1, {4'h0, e}, nm);
    tick();
    CS_n = 1'b1; RD_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic px(input logic [8:0] vd, input logic d, input logic h,
                    input logic v, input logic [8:0] e, input string nm);
    VD = vd; in_disp = d; HSYNC_n_in = h; VSYNC_n_in = v;
    push(cyc + 2, 0, {e, h, v, d}, nm);
    tick();
  endtask

  task automatic idle();
    in_disp = 1'b0; HSYNC_n_in = 1'b1; VSYNC_n_in = 1'b1;
  endtask

  localparam logic [8:0] BW_1FF = 9'h1FF;
`ifdef VCE_BW_MODE_EN
  localparam logic [8:0] BW_038 = 9'h049;
`else
  localparam logic [8:0] BW_038 = 9'h038;
`endif

  initial begin
    // Reset state
    tick();
    push(cyc, 0, {9'h000, 1'b1, 1'b1, 1'b0}, "reset_pix");
    push(cyc, 1, 12'h0FF, "reset_do");
    tick();
    reset = 1'b0;
    tick();

    // pal[0] = 049 (CTA starts at 0), then the 0x123 entry
    w(3'd4, 8'h49); w(3'd5, 8'h00);
    w(3'd2, 8'h23); w(3'd3, 8'h01); w(3'd4, 8'hC7); w(3'd5, 8'h01);
    w(3'd4, 8'h55); w(3'd5, 8'h00);               // lands at 0x124
    px(9'h123, 1'b1, 1'b1, 1'b1, 9'h1C7, "pix_123");
    px(9'h124, 1'b1, 1'b1, 1'b1, 9'h055, "pix_124");
    idle(); tick();
    w(3'd2, 8'h24); rd(3'd6, 8'h55, "rd_lo_124"); rd(3'd7, 8'hFE, "rd_hi_124");
    w(3'd2, 8'h23); rd(3'd6, 8'hC7, "rd_lo_123"); rd(3'd7, 8'hFF, "rd_hi_123");

    // CTA wrap 0x1FF -> 0
    w(3'd2, 8'hFF); w(3'd3, 8'h01); w(3'd4, 8'h5A); w(3'd5, 8'h01);
    rd(3'd6, 8'h49, "rd_lo_wrap0"); rd(3'd7, 8'hFE, "rd_hi_wrap0");
    w(3'd4, 8'h3C); w(3'd5, 8'h01);               // lands at 0x001
    w(3'd2, 8'h01); w(3'd3, 8'h00);
    rd(3'd6, 8'h3C, "rd_lo_001"); rd(3'd7, 8'hFF, "rd_hi_001");
    w(3'd2, 8'hFF); w(3'd3, 8'h01);
    rd(3'd6, 8'h5A, "rd_lo_1ff"); rd(3'd7, 8'hFF, "rd_hi_1ff");
    px(9'h1FF, 1'b1, 1'b1, 1'b1, 9'h15A, "pix_1ff");
    idle(); tick();

    // Backdrop, overscan and sync alignment
    w(3'd2, 8'h00); w(3'd3, 8'h01); w(3'd4, 8'h07); w(3'd5, 8'h00);
    px(9'h0A0, 1'b1, 1'b1, 1'b1, 9'h049, "pix_bg_idx0");
    px(9'h1F0, 1'b1, 1'b1, 1'b1, 9'h049, "pix_spr_idx0");
    px(9'h123, 1'b0, 1'b1, 1'b1, 9'h007, "pix_overscan");
    px(9'h123, 1'b0, 1'b0, 1'b1, 9'h007, "pix_hsync");
    px(9'h123, 1'b0, 1'b1, 1'b0, 9'h007, "pix_vsync");
    px(9'h123, 1'b1, 1'b1, 1'b1, 9'h1C7, "pix_after_sync");
    idle(); tick();

    // Write strobe held low: exactly one table write
    w(3'd2, 8'h11); w(3'd3, 8'h00); w(3'd4, 8'h33); w(3'd5, 8'h00);
    w(3'd2, 8'h10); w(3'd4, 8'hAA);
    CS_n = 1'b0; WR_n = 1'b0; A = 3'd5; DI = 8'h01;
    repeat (5) tick();
    CS_n = 1'b1; WR_n = 1'b1;
    tick();
    rd(3'd6, 8'h33, "hold_cta_011"); rd(3'd7, 8'hFE, "hold_hi_011");
    w(3'd2, 8'h10);
    rd(3'd6, 8'hAA, "hold_lo_010"); rd(3'd7, 8'hFF, "hold_hi_010");

    // Same-cycle CPU write and pixel read of entry 0x021
    w(3'd2, 8'h21); w(3'd3, 8'h00); w(3'd4, 8'h01); w(3'd5, 8'h00);
    w(3'd2, 8'h21); w(3'd4, 8'h02);
    CS_n = 1'b0; WR_n = 1'b0; A = 3'd5; DI = 8'h00;
    VD = 9'h021; in_disp = 1'b1; HSYNC_n_in = 1'b1; VSYNC_n_in = 1'b1;
    push(cyc + 2, 0, {9'h001, 1'b1, 1'b1, 1'b1}, "collision_old");
    tick();
    CS_n = 1'b1; WR_n = 1'b1;
    px(9'h021, 1'b1, 1'b1, 1'b1, 9'h002, "collision_new");
    idle(); tick();

    // Black/white control
    w(3'd2, 8'hFF); w(3'd3, 8'h01); w(3'd4, 8'hFF); w(3'd5, 8'h01);
    w(3'd2, 8'h38); w(3'd3, 8'h00); w(3'd4, 8'h38); w(3'd5, 8'h00);
    w(3'd0, 8'h80);
    px(9'h1FF, 1'b1, 1'b1, 1'b1, BW_1FF, "bw_white");
    px(9'h038, 1'b1, 1'b1, 1'b1, BW_038, "bw_red");
    idle(); tick();
    w(3'd0, 8'h00);
    px(9'h038, 1'b1, 1'b1, 1'b1, 9'h038, "colour_red");
    idle();
    repeat (3) tick();

    // Reset in the middle of a pixel burst
    VD = 9'h123; in_disp = 1'b1; HSYNC_n_in = 1'b1; tick();
    HSYNC_n_in = 1'b0; tick();
    HSYNC_n_in = 1'b1; tick();
    reset = 1'b1;
    push(cyc, 0, {9'h000, 1'b1, 1'b1, 1'b0}, "midline_reset_pix");
    push(cyc, 1, 12'h0FF, "midline_reset_do");
    tick();
    push(cyc, 0, {9'h000, 1'b1, 1'b1, 1'b0}, "reset_held_pix");
    reset = 1'b0;
    idle(); tick();
    rd(3'd6, 8'h49, "post_reset_cta0"); rd(3'd7, 8'hFE, "post_reset_hi0");
    rd(3'd6, 8'h3C, "post_reset_001");
    w(3'd2, 8'h23); w(3'd3, 8'h01);
    rd(3'd6, 8'hC7, "post_reset_lo_123"); rd(3'd7, 8'hFF, "post_reset_hi_123");
    px(9'h123, 1'b1, 1'b1, 1'b1, 9'h1C7, "post_reset_pix");
    idle();

    // Drain the scoreboard
    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations pending, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
